// File: rtl/diff_freq_serializer.sv
// diff_freq_serializer: packet-driven 3-channel pattern serializer with per-bit low/high speed
// Ports: clk; rst_n (asynchronous, active-high); i_data/i_rx_done_tick (received UART bytes);
//   o_serial_out0..2 (channel outputs); o_bit_tick (any channel starts a bit);
//   o_done_tick (a one-shot channel finished).
// Optional feature: define PACKET_TIMEOUT_EN to discard a partial packet after TIMEOUT_CLKS idle clocks.
module diff_freq_serializer #(
  parameter int DATA_BIT     = 32,
  parameter int PACK_NUM     = (2*DATA_BIT+8)/8,
  parameter int LOW_DIV      = 20,
  parameter int HIGH_DIV     = 10,
  parameter int TIMEOUT_CLKS = 20000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] i_data,
  input  logic       i_rx_done_tick,
  output logic       o_serial_out0,
  output logic       o_serial_out1,
  output logic       o_serial_out2,
  output logic       o_bit_tick,
  output logic       o_done_tick
);
  localparam int IDX_W = $clog2(DATA_BIT);
  localparam int DIV_W = $clog2((LOW_DIV > HIGH_DIV ? LOW_DIV : HIGH_DIV) + 1);
  localparam int PAY_W = 8*(PACK_NUM-1);
  localparam int BC_W  = $clog2(PACK_NUM);
  localparam logic [BC_W-1:0]  LAST    = BC_W'(PACK_NUM-1);
  localparam logic [DIV_W-1:0] LOW_LD  = DIV_W'(LOW_DIV-1);
  localparam logic [DIV_W-1:0] HIGH_LD = DIV_W'(HIGH_DIV-1);
  localparam logic [IDX_W-1:0] IDX_END = IDX_W'(DATA_BIT-1);
  logic [BC_W-1:0]     byte_cnt;
  logic [PAY_W-1:0]    pay;
  logic [7:0]          ctrl;
  logic                go, drop;
  logic [DATA_BIT-1:0] out_pat, freq_pat;
  logic [2:0]          run_q, run_d, idle_q, idle_d, rep_q, rep_d, start, stop, step, wrap;
  logic [2:0]          out_d, tick_d, done_d;
  logic [DATA_BIT-1:0] pat_q [3], pat_d [3], frq_q [3], frq_d [3];
  logic [IDX_W-1:0]    idx_q [3], idx_d [3], nidx [3];
  logic [DIV_W-1:0]    cnt_q [3], cnt_d [3];
`ifdef PACKET_TIMEOUT_EN
  localparam int GAP_W = $clog2(TIMEOUT_CLKS+1);
  logic [GAP_W-1:0] gap;
  assign drop = byte_cnt != '0 && gap == GAP_W'(TIMEOUT_CLKS-1);
  always_ff @(posedge clk or posedge rst_n)
    if (rst_n) gap <= '0;
    else gap <= (i_rx_done_tick || byte_cnt == '0) ? '0 : gap + GAP_W'(1);
`else
  assign drop = 1'b0;
`endif
  // Payload bytes shift in from the top so byte 0 lands in bits [7:0] once the packet is complete.
  always_ff @(posedge clk or posedge rst_n)
    if (rst_n) begin
      byte_cnt <= '0;
      pay      <= '0;
      ctrl     <= '0;
      go       <= 1'b0;
    end else begin
      go <= i_rx_done_tick && byte_cnt == LAST;
      if (i_rx_done_tick) begin
        byte_cnt <= byte_cnt == LAST ? '0 : byte_cnt + BC_W'(1);
        if (byte_cnt == LAST) ctrl <= i_data;
        else pay <= {i_data, pay[PAY_W-1:8]};
      end else if (drop) byte_cnt <= '0;
    end
  assign out_pat  = pay[DATA_BIT-1:0];
  assign freq_pat = pay[2*DATA_BIT-1:DATA_BIT];
  always_ff @(posedge clk or posedge rst_n)
    if (rst_n) begin
      run_q  <= '0;
      idle_q <= '0;
      rep_q  <= '0;
      for (int c = 0; c < 3; c++) begin
        pat_q[c] <= '0;
        frq_q[c] <= '0;
        idx_q[c] <= '0;
        cnt_q[c] <= '0;
      end
      {o_serial_out2, o_serial_out1, o_serial_out0} <= '0;
      o_bit_tick  <= 1'b0;
      o_done_tick <= 1'b0;
    end else begin
      run_q  <= run_d;
      idle_q <= idle_d;
      rep_q  <= rep_d;
      for (int c = 0; c < 3; c++) begin
        pat_q[c] <= pat_d[c];
        frq_q[c] <= frq_d[c];
        idx_q[c] <= idx_d[c];
        cnt_q[c] <= cnt_d[c];
      end
      {o_serial_out2, o_serial_out1, o_serial_out0} <= out_d;
      o_bit_tick  <= |tick_d;
      o_done_tick <= |done_d;
    end
  // A command for a channel overrides its playback in the same cycle; stop beats a bit boundary.
  always_comb
    for (int c = 0; c < 3; c++) begin
      start[c]  = go && ctrl[7:4] == 4'(c) && ctrl[1:0] == 2'b01;
      stop[c]   = go && ctrl[7:4] == 4'(c) && ctrl[1:0] == 2'b10;
      step[c]   = run_q[c] && cnt_q[c] == '0;
      wrap[c]   = step[c] && idx_q[c] == IDX_END;
      nidx[c]   = wrap[c] ? '0 : idx_q[c] + IDX_W'(1);
      run_d[c]  = start[c] || (run_q[c] && !stop[c] && !(wrap[c] && !rep_q[c]));
      idle_d[c] = (start[c] || stop[c]) ? ctrl[3] : idle_q[c];
      rep_d[c]  = start[c] ? ctrl[2] : rep_q[c];
      pat_d[c]  = start[c] ? out_pat : pat_q[c];
      frq_d[c]  = start[c] ? freq_pat : frq_q[c];
      idx_d[c]  = start[c] ? '0 : step[c] ? nidx[c] : idx_q[c];
      cnt_d[c]  = start[c] ? (freq_pat[0] ? HIGH_LD : LOW_LD) :
                  step[c]  ? (frq_q[c][nidx[c]] ? HIGH_LD : LOW_LD) :
                  run_q[c] ? cnt_q[c] - DIV_W'(1) : cnt_q[c];
    end
  always_comb
    for (int c = 0; c < 3; c++) begin
      out_d[c]  = run_d[c] ? pat_d[c][idx_d[c]] : idle_d[c];
      tick_d[c] = run_d[c] && (start[c] || step[c]);
      done_d[c] = wrap[c] && !rep_q[c] && !start[c] && !stop[c];
    end
endmodule

// File: tb/tb_diff_freq_serializer.sv
// tb_diff_freq_serializer: scoreboard bench for diff_freq_serializer with an event-list reference model
module tb_diff_freq_serializer;
  localparam int LOW = 20;
  localparam int HIGH = 10;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [7:0] i_data = '0;
  logic i_rx_done_tick = 1'b0;
  logic o_serial_out0, o_serial_out1, o_serial_out2, o_bit_tick, o_done_tick;
  diff_freq_serializer dut (
    .clk(clk), .rst_n(rst_n), .i_data(i_data), .i_rx_done_tick(i_rx_done_tick),
    .o_serial_out0(o_serial_out0), .o_serial_out1(o_serial_out1), .o_serial_out2(o_serial_out2),
    .o_bit_tick(o_bit_tick), .o_done_tick(o_done_tick)
  );
  always #5 clk = ~clk;
  // kind: 0 = level change only, 1 = bit start (tick), 2 = one-shot done
  typedef struct { int cyc; int kind; int ch; logic val; } ev_t;
  ev_t q[$];
  int cyc = 0, tests = 0, fails = 0, ticks = 0, dones = 0;
  int rep_dl[3] = '{-1, -1, -1};
  logic [2:0] lvl = '0;
  bit mon_en = 1'b0;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      if (fails <= 30) $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask
  always @(negedge clk) if (mon_en) begin
    automatic bit et = 1'b0, ed = 1'b0;
    automatic ev_t keep[$];
    foreach (q[i]) begin
      if (q[i].cyc == cyc) begin
        lvl[q[i].ch] = q[i].val;
        et |= q[i].kind == 1;
        ed |= q[i].kind == 2;
      end else if (q[i].cyc < cyc) chk("stale_event", q[i].cyc, cyc);
      else keep.push_back(q[i]);
    end
    q = keep;
    chk("bit_tick", o_bit_tick, et);
    chk("done_tick", o_done_tick, ed);
    chk("outs", {o_serial_out2, o_serial_out1, o_serial_out0}, lvl);
    ticks += int'(o_bit_tick);
    dones += int'(o_done_tick);
  end
  task automatic purge(input int ch, input int s);
    ev_t k[$];
    foreach (q[i]) if (!(q[i].ch == ch && q[i].cyc >= s)) k.push_back(q[i]);
    q = k;
  endtask
  // Playback as a list of timed events: bit k starts at s + sum of earlier bit periods.
  task automatic model(input logic [31:0] pat, input logic [31:0] frq, input logic [7:0] ctl, input int s);
    int ch, t, per;
    ch = int'(ctl[7:4]);
    if (ch > 2 || ctl[1:0] == 2'b00 || ctl[1:0] == 2'b11) return;
    purge(ch, s);
    rep_dl[ch] = -1;
    if (ctl[1:0] == 2'b10) begin
      q.push_back('{s, 0, ch, ctl[3]});
      return;
    end
    per = 0;
    for (int k = 0; k < 32; k++) per += frq[k] ? HIGH : LOW;
    t = s;
    for (int r = 0; r < (ctl[2] ? 3 : 1); r++)
      for (int k = 0; k < 32; k++) begin
        q.push_back('{t, 1, ch, pat[k]});
        t += frq[k] ? HIGH : LOW;
      end
    if (ctl[2]) rep_dl[ch] = s + 2*per;
    else q.push_back('{t, 2, ch, ctl[3]});
  endtask
  task automatic send_raw(input logic [7:0] b, input int gap);
    @(negedge clk);
    i_data = b;
    i_rx_done_tick = 1'b1;
    @(posedge clk);
    #1 i_rx_done_tick = 1'b0;
    repeat (gap) @(negedge clk);
  endtask
  task automatic send_pkt(input logic [31:0] pat, input logic [31:0] frq, input logic [7:0] ctl, input int maxgap);
    logic [63:0] body;
    body = {frq, pat};
    for (int i = 0; i < 8; i++) send_raw(body[8*i +: 8], $urandom_range(maxgap, 0));
    @(negedge clk);
    i_data = ctl;
    i_rx_done_tick = 1'b1;
    model(pat, frq, ctl, cyc + 2);
    @(posedge clk);
    #1 i_rx_done_tick = 1'b0;
  endtask
  task automatic do_reset();
    @(negedge clk);
    mon_en = 1'b0;
    #2 rst_n = 1'b1;
    #1 chk("reset_outs", {o_serial_out2, o_serial_out1, o_serial_out0, o_bit_tick, o_done_tick}, 0);
    q.delete();
    lvl = '0;
    rep_dl = '{-1, -1, -1};
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    mon_en = 1'b1;
  endtask
  initial begin
    int t0, d0;
    logic [7:0] ctl;
    logic [3:0] ch;
    logic [1:0] cmd;
    int r;
    #1 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_outs", {o_serial_out2, o_serial_out1, o_serial_out0, o_bit_tick, o_done_tick}, 0);
    rst_n = 1'b0;
    @(negedge clk);
    mon_en = 1'b1;
    t0 = ticks; d0 = dones;
    send_pkt(32'h00FF00FF, 32'h0, 8'h01, 0);
    repeat (660) @(negedge clk);
    chk("basic_ticks", ticks - t0, 32);
    chk("basic_done", dones - d0, 1);
    chk("basic_out0_after", o_serial_out0, 0);
    d0 = dones;
    send_pkt(32'h00FF00FF, 32'h0, 8'h15, 0);
    repeat (1500) @(negedge clk);
    send_pkt(32'h0, 32'h0, 8'h12, 0);
    repeat (40) @(negedge clk);
    chk("repeat_no_done", dones - d0, 0);
    chk("repeat_stopped_out1", o_serial_out1, 0);
    d0 = dones;
    send_pkt(32'h0000000F, 32'h00000003, 8'h21, 0);
    repeat (640) @(negedge clk);
    chk("mixed_done", dones - d0, 1);
    send_pkt(32'h0, 32'h0, 8'h09, 0);
    repeat (660) @(negedge clk);
    chk("idle_high_out0", o_serial_out0, 1);
    send_pkt(32'hFFFFFFFF, 32'h0, 8'hF1, 0);
    repeat (100) @(negedge clk);
    chk("invalid_ch_outs", {o_serial_out2, o_serial_out1, o_serial_out0}, 3'b001);
    send_pkt(32'hFFFFFFFF, 32'h0, 8'h09, 0);
    repeat (50) @(negedge clk);
    for (int i = 0; i < 4; i++) send_raw(8'h5A, 0);
    chk("pre_reset_out0", o_serial_out0, 1);
    do_reset();
    d0 = dones;
    send_pkt(32'h3C3C3C3C, 32'h0F0F0F0F, 8'h11, 1);
    repeat (660) @(negedge clk);
    chk("post_reset_done", dones - d0, 1);
`ifdef PACKET_TIMEOUT_EN
    for (int i = 0; i < 4; i++) send_raw(8'hA5, 0);
    repeat (20010) @(negedge clk);
    d0 = dones;
    send_pkt(32'h12345678, 32'h9ABCDEF0, 8'h21, 1);
    repeat (660) @(negedge clk);
    chk("timeout_done", dones - d0, 1);
`endif
    for (int n = 0; n < 30; n++) begin
      repeat ($urandom_range(120, 0)) @(negedge clk);
      for (int c = 0; c < 3; c++)
        if (rep_dl[c] >= 0 && cyc + 100 >= rep_dl[c]) send_pkt($urandom, $urandom, {4'(c), 1'($urandom), 1'b0, 2'b10}, 3);
      ch = ($urandom_range(9, 0) == 0) ? 4'($urandom_range(15, 3)) : 4'($urandom_range(2, 0));
      r = $urandom_range(9, 0);
      cmd = r < 6 ? 2'b01 : r < 8 ? 2'b10 : r == 8 ? 2'b00 : 2'b11;
      ctl = {ch, 1'($urandom), 1'($urandom), cmd};
      send_pkt($urandom, $urandom, ctl, 3);
    end
    for (int c = 0; c < 3; c++) send_pkt(32'h0, 32'h0, {4'(c), 4'b0010}, 0);
    repeat (700) @(negedge clk);
    chk("queue_empty", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
